// File: rtl/div_seq_if.sv
// div_seq_if: start/busy/done handshake and operand/result bus of div_seq.
//   start        requester -> divider  request a division
//   A, B         requester -> divider  dividend / divisor (N bits, unsigned)
//   Q, R         divider -> requester  quotient / remainder (N bits)
//   busy         divider -> requester  division in progress
//   done         divider -> requester  result valid pulse
//   div_by_zero  divider -> requester  last result came from B==0
// master = requester side, slave = divider side.
interface div_seq_if #(parameter int N = 4);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  modport master (output start, A, B, input Q, R, busy, done, div_by_zero);
  modport slave  (input start, A, B, output Q, R, busy, done, div_by_zero);
endinterface

// File: rtl/div_seq.sv
// div_seq: sequential unsigned restoring divider, one quotient bit per clock.
//   Q = A / B, R = A % B; N iterations after the accepting edge.
//   B == 0 short-circuits to DONE with Q = all ones, R = A, div_by_zero = 1.
// Ports:
//   CLK      system clock, rising edge
//   n_reset  asynchronous active-low reset
//   bus      div_seq_if.slave (start, A, B in; Q, R, busy, done, div_by_zero out)
// Optional feature macro: DIV_CHECK_EN
//   Defined   -> operands are captured and every non-zero-divisor result is checked
//                against Q*B + R == A and R < B by an immediate assertion.
//   Undefined -> no capture registers, no checker; port behaviour unchanged.
module div_seq #(
  parameter int N = 4
) (
  input  logic      CLK,
  input  logic      n_reset,
  div_seq_if.slave  bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [N:0]    rem;
  logic [N-1:0]  quo;
  logic [N-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic [N-1:0]  q_r, r_r;
  logic          dbz_r;

  logic          accept, last, b_zero;
  logic [N:0]    t, rem_nxt;
  logic          ge;
  logic [N-1:0]  quo_nxt;

  // New requests are only taken when no division is running.
  assign accept = ((state == IDLE) || (state == DONE)) && bus.start;
  assign b_zero = (bus.B == '0);
  assign last   = (cnt == CW'(1));

  // One restoring step. rem[N] is always 0 after a restore, but if it were
  // set the shifted value would exceed any divisor, so it forces a subtract.
  always_comb begin
    t       = {rem[N-1:0], quo[N-1]};
    ge      = rem[N] | (t >= {1'b0, dvs});
    rem_nxt = ge ? (t - {1'b0, dvs}) : t;
    quo_nxt = {quo[N-2:0], ge};
  end

  // State register
  always_ff @(posedge CLK or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = b_zero ? DONE : CALC;
      CALC:    if (last)   state_nxt = DONE;
      DONE:    if (accept) state_nxt = b_zero ? DONE : CALC;
               else        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy        = (state == CALC);
    bus.done        = (state == DONE);
    bus.Q           = q_r;
    bus.R           = r_r;
    bus.div_by_zero = dbz_r;
  end

  // Datapath; Q/R/div_by_zero only change when a new result is produced.
  always_ff @(posedge CLK or negedge n_reset) begin
    if (!n_reset) begin
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      q_r   <= '0;
      r_r   <= '0;
      dbz_r <= 1'b0;
    end else if (accept) begin
      if (b_zero) begin
        q_r   <= '1;
        r_r   <= bus.A;
        dbz_r <= 1'b1;
      end else begin
        rem <= '0;
        quo <= bus.A;
        dvs <= bus.B;
        cnt <= CW'(N);
      end
    end else if (state == CALC) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      cnt <= cnt - CW'(1);
      if (last) begin
        q_r   <= quo_nxt;
        r_r   <= rem_nxt[N-1:0];
        dbz_r <= 1'b0;
      end
    end
  end

`ifdef DIV_CHECK_EN
  logic [N-1:0] A_cap, B_cap;

  always_ff @(posedge CLK or negedge n_reset) begin
    if (!n_reset) begin
      A_cap <= '0;
      B_cap <= '0;
    end else if (accept) begin
      A_cap <= bus.A;
      B_cap <= bus.B;
    end
  end

  // Sampled on the edge that closes the done cycle, while Q/R still hold.
  always @(posedge CLK) begin
    if (n_reset && (state == DONE) && !dbz_r) begin
      assert ((((2*N)'(q_r) * (2*N)'(B_cap)) + (2*N)'(r_r) == (2*N)'(A_cap))
              && (r_r < B_cap))
      else $error("div_seq self-check: A=%0d B=%0d Q=%0d R=%0d", A_cap, B_cap, q_r, r_r);
    end
  end
`endif

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;
  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  div_seq_if #(.N(4)) bus();

  div_seq #(.N(4)) dut (
    .CLK     (clk),
    .n_reset (n_reset),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Presents one request for one cycle, then waits for
  // done (bounded). lat counts cycles from the cycle start was presented.
  // poke: re-pulse start with A=15,B=1 during the division.
  task automatic run_div(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] eq, input logic [3:0] er, input logic edbz,
                         input int elat, input int ebusy, input bit poke);
    int lat;
    int nbusy;
    lat   = 0;
    nbusy = 0;
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus.start = 1'b0;
      if (poke && lat == 2) begin bus.A = 4'd15; bus.B = 4'd1; bus.start = 1'b1; end
      if (poke && lat == 3) bus.start = 1'b0;
      if (bus.busy) nbusy++;
    end while (!bus.done && lat < 20);
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " busy cycles"}, 32'(nbusy), 32'(ebusy));
    chk({tag, " busy at done"}, 32'(bus.busy), 32'(0));
    chk({tag, " Q"}, 32'(bus.Q), 32'(eq));
    chk({tag, " R"}, 32'(bus.R), 32'(er));
    chk({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(edbz));
    @(negedge clk);
    chk({tag, " done pulse ends"}, 32'(bus.done), 32'(0));
    chk({tag, " Q held"}, 32'(bus.Q), 32'(eq));
  endtask

  initial begin
    int lat;
    logic [3:0] eq, er;
    n_reset   = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(negedge clk);
    chk("reset Q", 32'(bus.Q), 32'(0));
    chk("reset R", 32'(bus.R), 32'(0));
    chk("reset busy", 32'(bus.busy), 32'(0));
    chk("reset done", 32'(bus.done), 32'(0));
    chk("reset div_by_zero", 32'(bus.div_by_zero), 32'(0));
    n_reset = 1'b1;
    @(negedge clk);

    // T1..T4
    run_div("t1 0/1",   4'd0,  4'd1,  4'd0,  4'd0, 1'b0, 5, 4, 1'b0);
    run_div("t2 15/15", 4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 5, 4, 1'b0);
    run_div("t2 13/4",  4'd13, 4'd4,  4'd3,  4'd1, 1'b0, 5, 4, 1'b0);
    run_div("t2 3/7",   4'd3,  4'd7,  4'd0,  4'd3, 1'b0, 5, 4, 1'b0);
    run_div("t3 9/0",   4'd9,  4'd0,  4'd15, 4'd9, 1'b1, 1, 0, 1'b0);
    run_div("t4 14/3",  4'd14, 4'd3,  4'd4,  4'd2, 1'b0, 5, 4, 1'b1);

    // T5: reset in the second CALC cycle; Q=4,R=2 from T4 must clear at once.
    bus.A = 4'd7;
    bus.B = 4'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t5 busy before reset", 32'(bus.busy), 32'(1));
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    chk("t5 async busy", 32'(bus.busy), 32'(0));
    chk("t5 async done", 32'(bus.done), 32'(0));
    chk("t5 async Q", 32'(bus.Q), 32'(0));
    chk("t5 async R", 32'(bus.R), 32'(0));
    chk("t5 async div_by_zero", 32'(bus.div_by_zero), 32'(0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5 no done in reset", 32'(bus.done), 32'(0));
      if (i == 2) n_reset = 1'b1;
    end
    run_div("t5 12/5", 4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 5, 4, 1'b0);

    // T6: exhaustive sweep, start held high, next pair presented in the done cycle.
    bus.start = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        bus.A = 4'(a);
        bus.B = 4'(b);
        if (b == 0) begin
          eq = 4'd15;
          er = 4'(a);
        end else begin
          eq = 4'(a / b);
          er = 4'(a % b);
        end
        lat = 0;
        do begin
          @(negedge clk);
          lat++;
        end while (!bus.done && lat < 20);
        chk($sformatf("t6 %0d/%0d latency", a, b), 32'(lat), (b == 0) ? 32'(1) : 32'(5));
        chk($sformatf("t6 %0d/%0d Q", a, b), 32'(bus.Q), 32'(eq));
        chk($sformatf("t6 %0d/%0d R", a, b), 32'(bus.R), 32'(er));
        chk($sformatf("t6 %0d/%0d div_by_zero", a, b), 32'(bus.div_by_zero),
            (b == 0) ? 32'(1) : 32'(0));
      end
    end
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6 idle after sweep", 32'(bus.done), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
